// File: rtl/io_bus_ctrl.sv
// -----------------------------------------------------------------------------
// io_bus_ctrl
//
// Memory-mapped I/O block that sits beside data RAM on the CPU bus.
//   9'h140  switches  read-only   {8'h00, sw_stable}
//   9'h100  LEDs      read/write  {8'h00, ledr}
//   9'h141  status    read-only   {14'h0, busy, chg}   (only with IO_STATUS_EN)
// All other addresses are not handled here, so io_en stays low for them.
//
// Reads are purely combinational: io_en and read_data are valid in the same
// cycle as the read command. Writes take effect at the clock edge.
//
// The slide switches are synchronised by two flops and then debounced. A new
// switch value is accepted only after it has held for DEBOUNCE_CYCLES cycles.
//
// Optional feature (compile-time macro IO_STATUS_EN):
//   Maps the status register at 9'h141. busy is high while a candidate value
//   is being timed. chg is a sticky flag that is set when a new switch value
//   is accepted. A status read clears chg at that edge, but an acceptance on
//   the same edge wins, so the flag stays set.
//
// Ports
//   clk         in   1   single clock, rising edge
//   reset       in   1   synchronous, active-high
//   mem_cmd     in   2   2'b00 write, 2'b01 read, others no-op
//   mem_addr    in   9   bus address, bit 8 = I/O space
//   write_data  in  16   store data; only [7:0] is used (LED register)
//   sw_in       in   8   raw asynchronous slide switches
//   read_data   out 16   read value, 16'h0000 when io_en is low
//   io_en       out  1   current read hits a mapped I/O register
//   ledr        out  8   LED register
// -----------------------------------------------------------------------------
module io_bus_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    input  logic [7:0]  sw_in,
    output logic [15:0] read_data,
    output logic        io_en,
    output logic [7:0]  ledr
);

    localparam logic [1:0]  CMD_WR   = 2'b00;
    localparam logic [1:0]  CMD_RD   = 2'b01;
    localparam logic [8:0]  ADDR_LED = 9'h100;
    localparam logic [8:0]  ADDR_SW  = 9'h140;
`ifdef IO_STATUS_EN
    localparam logic [8:0]  ADDR_STAT = 9'h141;
`endif
    localparam logic [19:0] C_DB     = 20'(DEBOUNCE_CYCLES);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;      // sw_sync
    logic [7:0]  r_cand;
    logic [7:0]  w_cand_next;
    logic [7:0]  r_stable;
    logic [19:0] r_cnt;
    logic [19:0] w_cnt_next;
    logic        w_accept;
    logic [7:0]  r_led;
    logic        w_led_wr;

    // The upper store byte has no destination; only the LED byte is kept.
    logic [7:0]  w_unused_wdata;
    assign w_unused_wdata = write_data[15:8];

    assign w_led_wr = (mem_cmd == CMD_WR) && (mem_addr == ADDR_LED);
    assign ledr     = r_led;

    // -------------------------------------------------------------------------
    // Synchroniser, debounce state and LED register.
    // The 8 switch bits are synchronised independently. A skewed multi-bit
    // change only shows up as a short-lived candidate, and the debounce logic
    // restarts on it, so no coherent-capture scheme is needed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 8'h00;
            r_sync2  <= 8'h00;
            r_state  <= S_IDLE;
            r_cand   <= 8'h00;
            r_cnt    <= 20'd0;
            r_stable <= 8'h00;
            r_led    <= 8'h00;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cand  <= w_cand_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_stable <= r_cand;
            end
            if (w_led_wr) begin
                r_led <= write_data[7:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Debounce next-state logic.
    // In COUNT the checks run in this order:
    //   1. A return to the stable value cancels the candidate.
    //   2. A third value restarts timing on that value.
    //   3. Otherwise the candidate is accepted once it has held for the
    //      full period, or the count advances by one.
    // The count stops at the accept threshold, so it cannot wrap.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cand_next  = r_cand;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_sync2 != r_stable) begin
                    w_state_next = S_COUNT;
                    w_cand_next  = r_sync2;
                    w_cnt_next   = 20'd1;
                end else begin
                    w_cnt_next   = 20'd0;
                end
            end
            S_COUNT: begin
                if (r_sync2 == r_stable) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 20'd0;
                end else if (r_sync2 != r_cand) begin
                    w_cand_next  = r_sync2;
                    w_cnt_next   = 20'd1;
                end else if (r_cnt >= C_DB) begin
                    w_accept     = 1'b1;
                    w_state_next = S_IDLE;
                    w_cnt_next   = 20'd0;
                end else begin
                    w_cnt_next   = r_cnt + 20'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 20'd0;
            end
        endcase
    end

`ifdef IO_STATUS_EN
    // -------------------------------------------------------------------------
    // Sticky change flag. An acceptance has priority over the clear that a
    // status read performs on the same edge.
    // -------------------------------------------------------------------------
    logic r_chg;
    logic w_stat_rd;

    assign w_stat_rd = (mem_cmd == CMD_RD) && (mem_addr == ADDR_STAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_chg <= 1'b0;
        end else if (w_accept) begin
            r_chg <= 1'b1;
        end else if (w_stat_rd) begin
            r_chg <= 1'b0;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Combinational read decode.
    // -------------------------------------------------------------------------
    always_comb begin
        io_en     = 1'b0;
        read_data = 16'h0000;
        if (mem_cmd == CMD_RD) begin
            case (mem_addr)
                ADDR_SW: begin
                    io_en     = 1'b1;
                    read_data = {8'h00, r_stable};
                end
                ADDR_LED: begin
                    io_en     = 1'b1;
                    read_data = {8'h00, r_led};
                end
`ifdef IO_STATUS_EN
                ADDR_STAT: begin
                    io_en     = 1'b1;
                    read_data = {14'h0000, (r_state == S_COUNT), r_chg};
                end
`endif
                default: begin
                    io_en     = 1'b0;
                    read_data = 16'h0000;
                end
            endcase
        end
    end

endmodule
